// File: rtl/downsample_mc.sv
// Multi-channel programmable decimator: pick-first or boxcar-sum per group of
// accepted samples, qualified by a valid strobe on a single clock.
module downsample_mc #(
   parameter int unsigned W       = 14,
   parameter int unsigned NCH     = 2,
   parameter int unsigned DEC_MAX = 20,
   parameter int unsigned DEC_W   = 5,
   parameter int unsigned GW      = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic                      mode_i,
   input  logic [DEC_W-1:0]          dec_i,
   input  logic                      valid_i,
   input  logic [NCH*W-1:0]          data_i,
   output logic                      valid_o,
   output logic [NCH*(W+GW)-1:0]     data_o
);

   localparam int unsigned OWO = W + GW;

   logic [DEC_W-1:0]   cnt_q, cnt_d;
   logic [DEC_W-1:0]   dec_q, dec_d;
   logic               mode_q, mode_d;
   logic [NCH*OWO-1:0] acc_q, acc_d;
   logic               valid_d;
   logic [NCH*OWO-1:0] data_d;

   logic               accept_c;
   logic               start_c;
   logic               last_c;
   logic               mode_cur_c;
   logic [DEC_W-1:0]   dec_in_c;
   logic [DEC_W-1:0]   dec_cur_c;
   logic [NCH*OWO-1:0] acc_nxt_c;

   // Clamp the requested factor into 1..DEC_MAX
   always_comb begin
      dec_in_c = dec_i;
      if (dec_i == '0) begin
         dec_in_c = DEC_W'(1);
      end else if (dec_i > DEC_W'(DEC_MAX)) begin
         dec_in_c = DEC_W'(DEC_MAX);
      end
   end

   // Group bookkeeping: factor and mode come from the inputs only at group start
   always_comb begin
      accept_c   = valid_i & en_i;
      start_c    = (cnt_q == '0);
      dec_cur_c  = start_c ? dec_in_c : dec_q;
      mode_cur_c = start_c ? mode_i : mode_q;
      last_c     = (cnt_q == (dec_cur_c - DEC_W'(1)));
   end

   // Per-channel accumulator update including the sample being accepted now
   always_comb begin
      acc_nxt_c = acc_q;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         if (start_c) begin
            acc_nxt_c[ch*OWO +: OWO] = {{GW{data_i[ch*W + W - 1]}}, data_i[ch*W +: W]};
         end else if (mode_cur_c) begin
            acc_nxt_c[ch*OWO +: OWO] = acc_q[ch*OWO +: OWO]
                                     + {{GW{data_i[ch*W + W - 1]}}, data_i[ch*W +: W]};
         end
      end
   end

   // Next-state and output values
   always_comb begin
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      valid_d = 1'b0;
      data_d  = data_o;
      if (!en_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (accept_c) begin
         acc_d = acc_nxt_c;
         if (start_c) begin
            dec_d  = dec_in_c;
            mode_d = mode_i;
         end
         if (last_c) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            data_d  = acc_nxt_c;
         end else begin
            cnt_d = cnt_q + DEC_W'(1);
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         dec_q   <= DEC_W'(1);
         mode_q  <= 1'b0;
         acc_q   <= '0;
         valid_o <= 1'b0;
         data_o  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         valid_o <= valid_d;
         data_o  <= data_d;
      end
   end

endmodule

// File: tb/tb_downsample_mc.sv
// Self-checking bench for downsample_mc against a queue-based group model.
module tb_downsample_mc;

   localparam int W     = 14;
   localparam int NCH   = 2;
   localparam int DEC_W = 5;
   localparam int OWO   = 19;

   logic                 clk_i = 1'b0;
   logic                 rst_n;
   logic                 en_i;
   logic                 mode_i;
   logic [DEC_W-1:0]     dec_i;
   logic                 valid_i;
   logic [NCH*W-1:0]     data_i;
   logic                 valid_o;
   logic [NCH*OWO-1:0]   data_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the samples of the open group, plus the expected outputs
   int q0[$];
   int q1[$];
   int g_dec;
   bit g_mode;
   bit m_valid;
   int m_data[2];

   downsample_mc dut (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .en_i    (en_i),
      .mode_i  (mode_i),
      .dec_i   (dec_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .valid_o (valid_o),
      .data_o  (data_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int qsum(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   function automatic int ch_out(input int ch);
      logic signed [OWO-1:0] t;
      t = data_o[ch*OWO +: OWO];
      return int'(t);
   endfunction

   function automatic int rnd_sample();
      return int'($urandom_range(0, 16383)) - 8192;
   endfunction

   // Apply one cycle of inputs, advance the model across the edge, settle 1ns past it
   task automatic drive(input bit rn, input bit en, input bit md, input int dec,
                        input bit vl, input int s0, input int s1);
      rst_n   = rn;
      en_i    = en;
      mode_i  = md;
      dec_i   = DEC_W'(dec);
      valid_i = vl;
      data_i  = {14'(s1), 14'(s0)};
      @(posedge clk_i);
      m_valid = 1'b0;
      if (!rn) begin
         q0.delete(); q1.delete();
         m_data[0] = 0; m_data[1] = 0;
      end else if (!en) begin
         q0.delete(); q1.delete();
      end else if (vl) begin
         if (q0.size() == 0) begin
            g_dec  = (dec == 0) ? 1 : ((dec > 20) ? 20 : dec);
            g_mode = md;
         end
         q0.push_back(s0);
         q1.push_back(s1);
         if (q0.size() == g_dec) begin
            m_valid   = 1'b1;
            m_data[0] = g_mode ? qsum(q0) : q0[0];
            m_data[1] = g_mode ? qsum(q1) : q1[0];
            q0.delete(); q1.delete();
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1, 4, 1'b1, 100, -100);
         n_tests++;
         if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset valid_o got %0b exp 0", valid_o);
         end
         n_tests++;
         if (data_o !== '0) begin
            n_fail++; $display("FAIL reset data_o got %h exp 0", data_o);
         end
      end
   endtask

   // Mode 0, dec=4, ramp on ch0 with random ch1
   task automatic test_pick();
      int outs = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b0, 4, 1'b1, i, rnd_sample());
         n_tests++;
         if (valid_o !== m_valid) begin
            n_fail++; $display("FAIL pick valid_o cyc %0d got %0b exp %0b", i, valid_o, m_valid);
         end
         if (m_valid) begin
            outs++;
            for (int ch = 0; ch < NCH; ch++) begin
               n_tests++;
               if (ch_out(ch) !== m_data[ch]) begin
                  n_fail++; $display("FAIL pick ch%0d cyc %0d got %0d exp %0d", ch, i, ch_out(ch), m_data[ch]);
               end
            end
            n_tests++;
            if (ch_out(0) !== i - 3) begin
               n_fail++; $display("FAIL pick_ramp got %0d exp %0d", ch_out(0), i - 3);
            end
         end
      end
      n_tests++;
      if (outs !== 4) begin
         n_fail++; $display("FAIL pick_count got %0d exp 4", outs);
      end
   endtask

   // Mode 1, dec=4 contiguous, then dec=3 with valid toggling
   task automatic test_sum();
      int r = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 1'b1, 4, 1'b1, i, -i);
         n_tests++;
         if (valid_o !== m_valid) begin
            n_fail++; $display("FAIL sum valid_o cyc %0d got %0b exp %0b", i, valid_o, m_valid);
         end
         if (m_valid) begin
            for (int ch = 0; ch < NCH; ch++) begin
               n_tests++;
               if (ch_out(ch) !== m_data[ch]) begin
                  n_fail++; $display("FAIL sum ch%0d cyc %0d got %0d exp %0d", ch, i, ch_out(ch), m_data[ch]);
               end
            end
         end
      end
      for (int i = 0; i < 24; i++) begin
         bit v = (i % 2 == 0);
         drive(1'b1, 1'b1, 1'b1, 3, v, v ? r : 999, v ? -r : 777);
         if (v) r++;
         n_tests++;
         if (valid_o !== m_valid) begin
            n_fail++; $display("FAIL gaps valid_o cyc %0d got %0b exp %0b", i, valid_o, m_valid);
         end
         if (m_valid) begin
            for (int ch = 0; ch < NCH; ch++) begin
               n_tests++;
               if (ch_out(ch) !== m_data[ch]) begin
                  n_fail++; $display("FAIL gaps ch%0d cyc %0d got %0d exp %0d", ch, i, ch_out(ch), m_data[ch]);
               end
            end
         end
      end
   endtask

   // Full-scale sums over the largest group
   task automatic test_fullscale();
      int v [2] = '{-8192, 8191};
      int e [2] = '{-163840, 163820};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b1, 20, 1'b1, v[k], v[k]);
            n_tests++;
            if (valid_o !== (i == 19)) begin
               n_fail++; $display("FAIL full valid_o k%0d cyc %0d got %0b", k, i, valid_o);
            end
         end
         for (int ch = 0; ch < NCH; ch++) begin
            n_tests++;
            if (ch_out(ch) !== e[k]) begin
               n_fail++; $display("FAIL full ch%0d got %0d exp %0d", ch, ch_out(ch), e[k]);
            end
         end
      end
   endtask

   // dec 4->2 mid-group, then dec=0 acting as 1 with back-to-back outputs
   task automatic test_dec_change();
      for (int i = 0; i < 14; i++) begin
         int d = (i < 2) ? 4 : ((i < 10) ? 2 : 0);
         drive(1'b1, 1'b1, 1'b1, d, 1'b1, rnd_sample(), rnd_sample());
         n_tests++;
         if (valid_o !== m_valid) begin
            n_fail++; $display("FAIL decchg valid_o cyc %0d got %0b exp %0b", i, valid_o, m_valid);
         end
         if (m_valid) begin
            for (int ch = 0; ch < NCH; ch++) begin
               n_tests++;
               if (ch_out(ch) !== m_data[ch]) begin
                  n_fail++; $display("FAIL decchg ch%0d cyc %0d got %0d exp %0d", ch, i, ch_out(ch), m_data[ch]);
               end
            end
         end
      end
   endtask

   // Reset and enable-low mid-group discard the partial group
   task automatic test_abort();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 7; i++) begin
            bit rn = !(k == 0 && i == 2);
            bit en = !(k == 1 && i == 2);
            drive(rn, en, 1'b1, 4, 1'b1, rnd_sample(), rnd_sample());
            n_tests++;
            if (valid_o !== m_valid) begin
               n_fail++; $display("FAIL abort%0d valid_o cyc %0d got %0b exp %0b", k, i, valid_o, m_valid);
            end
            for (int ch = 0; ch < NCH; ch++) begin
               n_tests++;
               if (ch_out(ch) !== m_data[ch]) begin
                  n_fail++; $display("FAIL abort%0d ch%0d cyc %0d got %0d exp %0d", k, ch, i, ch_out(ch), m_data[ch]);
               end
            end
         end
      end
   endtask

   // Random traffic across all controls
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bit rn = ($urandom_range(0, 99) != 0);
         bit en = ($urandom_range(0, 19) != 0);
         drive(rn, en, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               ($urandom_range(0, 3) != 0), rnd_sample(), rnd_sample());
         n_tests++;
         if (valid_o !== m_valid) begin
            n_fail++; $display("FAIL rand valid_o cyc %0d got %0b exp %0b", i, valid_o, m_valid);
         end
         for (int ch = 0; ch < NCH; ch++) begin
            n_tests++;
            if (ch_out(ch) !== m_data[ch]) begin
               n_fail++; $display("FAIL rand ch%0d cyc %0d got %0d exp %0d", ch, i, ch_out(ch), m_data[ch]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en_i = 1'b0; mode_i = 1'b0; dec_i = '0; valid_i = 1'b0; data_i = '0;
      m_valid = 1'b0; m_data[0] = 0; m_data[1] = 0; g_dec = 1; g_mode = 1'b0;
      test_reset();
      test_pick();
      test_reset();
      test_sum();
      test_fullscale();
      test_dec_change();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
